// File: rtl/bus_interface_unit.sv
// bus_interface_unit: request/response bridge between the core and the
// external memory bus. It registers address, write data and direction on
// acceptance, waits for mem_ready, and returns a one-cycle response pulse.
// Every output comes straight from a flop.
//
// Optional feature macro: BUS_IF_TIMEOUT_EN.
// When it is defined, an access aborts with rsp_error after TIMEOUT_CYCLES
// consecutive wait cycles. When it is undefined, the unit waits forever
// and rsp_error stays 0.
module bus_interface_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  READ_write,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mem_ready,
  output logic                  bus_active
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    IDLE       = 2'd1,
    ACCESS     = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   done;
  logic   abort;
  logic   timeout_hit;

`ifdef BUS_IF_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;

  // The last allowed wait cycle is the one where the counter already holds
  // TO_LIMIT-1 and mem_ready is still low. A limit of zero disables it.
  assign timeout_hit = (TO_LIMIT != 8'd0) && (wait_cnt == (TO_LIMIT - 8'd1));

  // Wait counter: cleared on acceptance, counts stalled ACCESS cycles and
  // saturates at the limit.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (accept) begin
      wait_cnt <= 8'd0;
    end else if ((state == ACCESS) && !mem_ready && (wait_cnt != TO_LIMIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic. Completion by mem_ready takes priority over the timeout.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      RESET_HOLD: begin
        state_next = IDLE;
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          state_next = ACCESS;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_next = IDLE;
          done       = 1'b1;
        end else if (timeout_hit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else begin
          state_next = ACCESS;
        end
      end
      default: begin
        state_next = RESET_HOLD;
      end
    endcase
  end

  // State register. The status outputs are registered from the next state
  // so that they line up with the state they describe.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= RESET_HOLD;
      req_ready  <= 1'b0;
      bus_active <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
    end else begin
      state      <= state_next;
      req_ready  <= (state_next == IDLE);
      bus_active <= (state_next == ACCESS);
      rsp_valid  <= done | abort;
      rsp_error  <= abort;
    end
  end

  // Bus latches. READ_write doubles as the stored direction for the whole
  // access and drops back to read as soon as the access ends.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      address_out <= {ADDR_WIDTH{1'b0}};
      data_out    <= {DATA_WIDTH{1'b0}};
      READ_write  <= 1'b0;
    end else if (accept) begin
      address_out <= req_addr;
      data_out    <= req_wdata;
      READ_write  <= req_write;
    end else if (state_next != ACCESS) begin
      READ_write  <= 1'b0;
    end
  end

  // Read-data latch: captures data_in on a good read, all-ones on an
  // aborted read, and keeps its value across writes.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= {DATA_WIDTH{1'b0}};
    end else if (done && !READ_write) begin
      rsp_rdata <= data_in;
    end else if (abort && !READ_write) begin
      rsp_rdata <= {DATA_WIDTH{1'b1}};
    end
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit (default 8-bit data, 16-bit
// address). Expected responses go into a queue when a request is accepted
// and are compared when rsp_valid pulses.
module tb_bus_interface_unit;

  logic        clk_in;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_error;
  logic [7:0]  rsp_rdata;
  logic        READ_write;
  logic [15:0] address_out;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        mem_ready;
  logic        bus_active;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] model_rdata = 8'h00;

`ifdef BUS_IF_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam int TO = 15;

  bus_interface_unit dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_error   (rsp_error),
    .rsp_rdata   (rsp_rdata),
    .READ_write  (READ_write),
    .address_out (address_out),
    .data_out    (data_out),
    .data_in     (data_in),
    .mem_ready   (mem_ready),
    .bus_active  (bus_active)
  );

  // Free-running clock.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid cycle must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rsp_error", 32'(rsp_error), 32'(e.err));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Single access with 'waits' stall cycles. Call just after a posedge.
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int waits);
    int   guard;
    bit   to_hit;
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    mem_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk_in); #1;
      guard++;
    end
    check_eq("accept_wait", 32'(guard < 20), 32'd1);
    to_hit = TIMEOUT_ON && (waits >= TO);
    if (wr) begin
      e.err = 1'b0; e.rdata = model_rdata;
    end else if (to_hit) begin
      e.err = 1'b1; e.rdata = 8'hFF;
    end else begin
      e.err = 1'b0; e.rdata = rd;
    end
    model_rdata = e.rdata;
    sb.push_back(e);
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    req_addr  = 16'hDEAD;
    req_wdata = 8'h00;
    for (int k = 0; k < 300; k++) begin
      mem_ready = (k == waits);
      data_in   = (k == waits) ? rd : ~rd;
      @(negedge clk_in);
      check_eq("acc_bus_active", 32'(bus_active), 32'd1);
      check_eq("acc_read_write", 32'(READ_write), 32'(wr));
      check_eq("acc_address", 32'(address_out), 32'(addr));
      check_eq("acc_data_out", 32'(data_out), 32'(wd));
      check_eq("acc_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk_in); #1;
      if ((k == waits) || (to_hit && (k == TO - 1))) break;
    end
    mem_ready = 1'b0;
    check_eq("end_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("end_req_ready", 32'(req_ready), 32'd1);
    check_eq("end_bus_active", 32'(bus_active), 32'd0);
    check_eq("end_read_write", 32'(READ_write), 32'd0);
    check_eq("end_addr_hold", 32'(address_out), 32'(addr));
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    data_in   = 8'h00;
    mem_ready = 1'b0;

    // Reset values.
    @(negedge clk_in);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_error", 32'(rsp_error), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_read_write", 32'(READ_write), 32'd0);
    check_eq("rst_address", 32'(address_out), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_bus_active", 32'(bus_active), 32'd0);

    // Release away from the edge; req_ready rises one edge later.
    @(posedge clk_in); #1;
    reset = 1'b1;
    @(negedge clk_in);
    check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk_in); #1;
    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    check_eq("idle_read_write", 32'(READ_write), 32'd0);

    // Zero-wait read, then a write with 3 waits, then assorted accesses.
    do_access(1'b0, 16'h1234, 8'h00, 8'hA5, 0);
    do_access(1'b1, 16'h0200, 8'h3C, 8'h77, 3);
    do_access(1'b0, 16'hBEEF, 8'h11, 8'h5A, 2);
    // Long stall: aborts at 15 cycles with the timeout, else completes.
    do_access(1'b0, 16'h0F0F, 8'h22, 8'hC3, 20);
    // mem_ready on the 15th ACCESS cycle wins over the timeout.
    do_access(1'b0, 16'h0F10, 8'h33, 8'h96, TO - 1);
    do_access(1'b1, 16'hFFFF, 8'hFF, 8'h00, 0);

    // Back-to-back reads with req_valid held high and zero waits.
    req_valid = 1'b1;
    req_write = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      req_addr = 16'h0100 + 16'(i);
      data_in  = 8'h10 + 8'(i);
      e.err = 1'b0; e.rdata = data_in;
      model_rdata = data_in;
      sb.push_back(e);
      check_eq("b2b_ready_pre", 32'(req_ready), 32'd1);
      @(posedge clk_in); #1;
      check_eq("b2b_busy", 32'(bus_active), 32'd1);
      check_eq("b2b_addr", 32'(address_out), 32'(req_addr));
      check_eq("b2b_not_ready", 32'(req_ready), 32'd0);
      @(posedge clk_in); #1;
      check_eq("b2b_rsp_with_ready", 32'(rsp_valid & req_ready), 32'd1);
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk_in); #1;

    // Reset during the second wait cycle of a write: no response expected.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h4321;
    req_wdata = 8'h5E;
    check_eq("mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    check_eq("mid_rw_busy", 32'(READ_write), 32'd1);
    @(posedge clk_in); #3;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_rw", 32'(READ_write), 32'd0);
    check_eq("mid_rst_addr", 32'(address_out), 32'd0);
    check_eq("mid_rst_data", 32'(data_out), 32'd0);
    check_eq("mid_rst_busy", 32'(bus_active), 32'd0);
    check_eq("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    model_rdata = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b1;
    @(posedge clk_in); #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);

    // One more read after reset recovery.
    do_access(1'b0, 16'h00AA, 8'h00, 8'h3D, 1);
    repeat (3) @(posedge clk_in);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
